// File: rtl/seq_det_scheduler.sv
// Streams parallel words MSB-first into a serial Mealy detector and reports
// per-word hit count, first-hit index and a saturating running total.
module seq_det_scheduler #(
  parameter int unsigned W  = 8,
  parameter int unsigned CW = 4,
  parameter int unsigned TW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_data,
  output logic          det_x,
  output logic          det_rst,
  input  logic          det_y,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] out_count,
  output logic [CW-1:0] out_first,
  output logic          out_hit,
  output logic [TW-1:0] total_hits,
  output logic          total_sat
);

  localparam logic [CW-1:0] FIRST_NONE = CW'(W);
  localparam logic [CW-1:0] LAST_IDX   = CW'(W - 1);
  localparam logic [TW:0]   TOTAL_MAX  = {1'b0, {TW{1'b1}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_REPORT
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_shift, w_shift_nxt;
  logic [CW-1:0] r_idx, w_idx_nxt;
  logic [CW-1:0] r_count, w_count_nxt;
  logic [CW-1:0] r_first, w_first_nxt;
  logic          r_hit, w_hit_nxt;
  logic [TW-1:0] r_total, w_total_nxt;
  logic          r_sat, w_sat_nxt;
  logic [TW:0]   w_sum;
  logic          r_det_rst;
  logic          r_in_ready;
  logic          r_out_valid;

  // Next-state and datapath update; total is folded in on the last SHIFT edge.
  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_idx_nxt   = r_idx;
    w_count_nxt = r_count;
    w_first_nxt = r_first;
    w_hit_nxt   = r_hit;
    w_total_nxt = r_total;
    w_sat_nxt   = r_sat;
    w_sum       = '0;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_state_nxt = S_SHIFT;
          w_shift_nxt = in_data;
          w_idx_nxt   = '0;
          w_count_nxt = '0;
          w_first_nxt = FIRST_NONE;
          w_hit_nxt   = 1'b0;
        end
      end
      S_SHIFT: begin
        if (det_y) begin
          w_count_nxt = r_count + CW'(1);
          w_hit_nxt   = 1'b1;
          if (r_first == FIRST_NONE) begin
            w_first_nxt = r_idx;
          end
        end
        w_shift_nxt = {r_shift[W-2:0], 1'b0};
        w_idx_nxt   = r_idx + CW'(1);
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_REPORT;
          w_sum       = {1'b0, r_total} + (TW+1)'(w_count_nxt);
          if (w_sum > TOTAL_MAX) begin
            w_total_nxt = '1;
            w_sat_nxt   = 1'b1;
          end else begin
            w_total_nxt = w_sum[TW-1:0];
          end
        end
      end
      S_REPORT: begin
        if (out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and registered handshake/detector-reset outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_idx       <= '0;
      r_count     <= '0;
      r_first     <= FIRST_NONE;
      r_hit       <= 1'b0;
      r_total     <= '0;
      r_sat       <= 1'b0;
      r_det_rst   <= 1'b1;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_shift     <= w_shift_nxt;
      r_idx       <= w_idx_nxt;
      r_count     <= w_count_nxt;
      r_first     <= w_first_nxt;
      r_hit       <= w_hit_nxt;
      r_total     <= w_total_nxt;
      r_sat       <= w_sat_nxt;
      r_det_rst   <= (w_state_nxt != S_SHIFT);
      r_in_ready  <= (w_state_nxt == S_IDLE);
      r_out_valid <= (w_state_nxt == S_REPORT);
    end
  end

  assign det_x      = (r_state == S_SHIFT) & r_shift[W-1];
  assign det_rst    = r_det_rst;
  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_count  = r_count;
  assign out_first  = r_first;
  assign out_hit    = r_hit;
  assign total_hits = r_total;
  assign total_sat  = r_sat;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: two instances (TW=16 and TW=4) on shared stimulus,
// each driving its own overlapping 1011 Mealy detector model.
module tb_seq_det_scheduler;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] in_data;

  logic        in_ready_a, det_x_a, det_rst_a, det_y_a, out_valid_a, out_hit_a, sat_a;
  logic [3:0]  out_count_a, out_first_a;
  logic [15:0] total_a;
  logic        in_ready_b, det_x_b, det_rst_b, det_y_b, out_valid_b, out_hit_b, sat_b;
  logic [3:0]  out_count_b, out_first_b;
  logic [3:0]  total_b;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int last_acc = 0;
  int gap = 0;
  int m_total_a = 0;
  int m_total_b = 0;
  int m_sat_a = 0;
  int m_sat_b = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  seq_det_scheduler #(.W(W), .CW(CW), .TW(16)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
    .det_x(det_x_a), .det_rst(det_rst_a), .det_y(det_y_a), .out_valid(out_valid_a),
    .out_ready(out_ready), .out_count(out_count_a), .out_first(out_first_a),
    .out_hit(out_hit_a), .total_hits(total_a), .total_sat(sat_a)
  );

  seq_det_scheduler #(.W(W), .CW(CW), .TW(4)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
    .det_x(det_x_b), .det_rst(det_rst_b), .det_y(det_y_b), .out_valid(out_valid_b),
    .out_ready(out_ready), .out_count(out_count_b), .out_first(out_first_b),
    .out_hit(out_hit_b), .total_hits(total_b), .total_sat(sat_b)
  );

  // Overlapping 1011 detectors: remember the last three bits since reset.
  logic [2:0] hist_a = 3'b000, hist_b = 3'b000;
  int         nb_a = 0, nb_b = 0;
  always @(posedge clk) begin
    if (det_rst_a) begin
      hist_a <= 3'b000; nb_a <= 0;
    end else begin
      hist_a <= {hist_a[1:0], det_x_a}; if (nb_a < 3) nb_a <= nb_a + 1;
    end
    if (det_rst_b) begin
      hist_b <= 3'b000; nb_b <= 0;
    end else begin
      hist_b <= {hist_b[1:0], det_x_b}; if (nb_b < 3) nb_b <= nb_b + 1;
    end
  end
  assign det_y_a = det_x_a && (nb_a == 3) && (hist_a == 3'b101);
  assign det_y_b = det_x_b && (nb_b == 3) && (hist_b == 3'b101);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: count every 4-bit window equal to 1011, MSB-first, within one word.
  function automatic void ref_scan(input logic [7:0] d, output int cnt, output int first);
    logic [3:0] win;
    cnt   = 0;
    first = W;
    for (int k = 3; k < W; k++) begin
      win = d[W+2-k -: 4];
      if (win == 4'b1011) begin
        cnt++;
        if (first == W) first = k;
      end
    end
  endfunction

  task automatic model_reset();
    m_total_a = 0; m_total_b = 0; m_sat_a = 0; m_sat_b = 0;
  endtask

  // Called at a negedge with the block expected idle (or about to be).
  task automatic run_word(input logic [7:0] d, input int hold, input bit keep_valid);
    int t, cnt, first;
    t = 0;
    out_ready = 1'b0;
    while (!in_ready_a && t < 40) begin
      @(negedge clk); t++;
    end
    check("in_ready_wait", 32'(in_ready_a), 1);
    gap = cyc - last_acc;
    last_acc = cyc;
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clk);
    if (!keep_valid) in_valid = 1'b0;
    for (int k = 0; k < W; k++) begin
      check("det_x_a", 32'(det_x_a), 32'(d[W-1-k]));
      check("det_x_b", 32'(det_x_b), 32'(d[W-1-k]));
      check("det_rst_shift", 32'(det_rst_a), 0);
      check("in_ready_shift", 32'(in_ready_a), 0);
      check("out_valid_shift", 32'(out_valid_a), 0);
      @(negedge clk);
    end
    ref_scan(d, cnt, first);
    m_total_a += cnt;
    if (m_total_a > 65535) begin m_total_a = 65535; m_sat_a = 1; end
    m_total_b += cnt;
    if (m_total_b > 15) begin m_total_b = 15; m_sat_b = 1; end
    for (int h = 0; h <= hold; h++) begin
      check("out_valid_a", 32'(out_valid_a), 1);
      check("out_valid_b", 32'(out_valid_b), 1);
      check("out_count_a", 32'(out_count_a), 32'(cnt));
      check("out_count_b", 32'(out_count_b), 32'(cnt));
      check("out_first_a", 32'(out_first_a), 32'(first));
      check("out_first_b", 32'(out_first_b), 32'(first));
      check("out_hit", 32'(out_hit_a), (cnt != 0) ? 1 : 0);
      check("total_a", 32'(total_a), 32'(m_total_a));
      check("total_b", 32'(total_b), 32'(m_total_b));
      check("sat_a", 32'(sat_a), 32'(m_sat_a));
      check("sat_b", 32'(sat_b), 32'(m_sat_b));
      check("det_rst_report", 32'(det_rst_a), 1);
      check("in_ready_report", 32'(in_ready_a), 0);
      check("det_x_report", 32'(det_x_a), 0);
      if (h < hold) @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_valid_drop", 32'(out_valid_a), 0);
    check("in_ready_back", 32'(in_ready_a), 1);
    check("det_rst_idle", 32'(det_rst_a), 1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = 8'h00;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready_a), 1);
    check("rst_det_rst", 32'(det_rst_a), 1);
    check("rst_det_x", 32'(det_x_a), 0);
    check("rst_out_valid", 32'(out_valid_a), 0);
    check("rst_out_count", 32'(out_count_a), 0);
    check("rst_out_first", 32'(out_first_a), 8);
    check("rst_out_hit", 32'(out_hit_a), 0);
    check("rst_total", 32'(total_a), 0);
    check("rst_sat", 32'(sat_a), 0);
    rst = 1'b0;
    @(negedge clk);

    // Reset in the middle of a scan.
    in_valid = 1'b1;
    in_data  = 8'hBB;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_rst_det_rst", 32'(det_rst_a), 0);
    rst = 1'b1;
    #1;
    check("midrst_det_rst", 32'(det_rst_a), 1);
    check("midrst_out_valid", 32'(out_valid_a), 0);
    check("midrst_in_ready", 32'(in_ready_a), 1);
    check("midrst_det_x", 32'(det_x_a), 0);
    check("midrst_total", 32'(total_a), 0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);

    // Directed words.
    run_word(8'b1011_1011, 0, 1'b0);
    run_word(8'b1101_1011, 1, 1'b0);
    check("total_after_two", 32'(total_a), 4);
    run_word(8'h00, 5, 1'b0);

    // Back-to-back with in_valid held high.
    run_word(8'hB5, 0, 1'b1);
    run_word(8'h2D, 0, 1'b1);
    check("b2b_gap1", 32'(gap), 10);
    run_word(8'hFB, 0, 1'b1);
    check("b2b_gap2", 32'(gap), 10);
    in_valid = 1'b0;

    // Randomized words.
    for (int i = 0; i < 24; i++) begin
      run_word(8'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    in_valid = 1'b0;

    // Saturation of the narrow total.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    for (int i = 0; i < 8; i++) run_word(8'b1011_1011, 0, 1'b0);
    check("sat_total_b", 32'(total_b), 15);
    check("sat_flag_b", 32'(sat_b), 1);
    check("nosat_total_a", 32'(total_a), 16);
    run_word(8'h00, 0, 1'b0);
    run_word(8'b1011_1011, 0, 1'b0);
    check("sat_sticky_b", 32'(sat_b), 1);
    check("sat_hold_b", 32'(total_b), 15);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
